// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned divider: ALU function codes,
// datapath width and controller state encoding.
package divu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [5:0] ALU_FUNCT_ADD = 6'b001001;
    localparam logic [5:0] ALU_FUNCT_SUB = 6'b001010;
    localparam logic [5:0] ALU_FUNCT_NOP = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Partial remainder shifted left with the next dividend bit brought in.
    function automatic logic [DATA_W-1:0] shift_in(
        input logic [DATA_W-1:0] rem,
        input logic [DATA_W-1:0] quo
    );
        return {rem[DATA_W-2:0], quo[DATA_W-1]};
    endfunction

endpackage

// File: rtl/divu_seq_ctrl.sv
// Sequencing controller for a 32-bit restoring divider that borrows an external add/sub ALU.
// Optional macro DIVU_ZERO_CHECK_EN short-circuits division by zero straight to DONE.
module divu_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [5:0]        alu_funct,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry
);
    import divu_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shifted_s;
    logic              accept_s;
    logic              last_s;
`ifdef DIVU_ZERO_CHECK_EN
    logic              dbz_q, dbz_d;
`endif

    assign shifted_s = shift_in(rem_q, quo_q);
    assign accept_s  = in_valid && (state_q == ST_IDLE);
    assign last_s    = (cnt_q == {CNT_W{1'b1}});

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIVU_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // Next-state, iteration datapath and ALU drive.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        alu_src1    = {DATA_W{1'b0}};
        alu_src2    = {DATA_W{1'b0}};
        alu_funct   = ALU_FUNCT_NOP;
`ifdef DIVU_ZERO_CHECK_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rem_d   = {DATA_W{1'b0}};
                    quo_d   = dividend;
                    dvs_d   = divisor;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_CALC;
`ifdef DIVU_ZERO_CHECK_EN
                    dbz_d   = 1'b0;
                    if (divisor == {DATA_W{1'b0}}) begin
                        state_d     = ST_DONE;
                        quotient_d  = {DATA_W{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d     = ST_CALC;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                alu_src1  = shifted_s;
                alu_src2  = dvs_q;
                alu_funct = ALU_FUNCT_SUB;
                // Borrow means the trial subtraction failed: restore the shifted remainder.
                if (alu_carry) begin
                    rem_d = shifted_s;
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end else begin
                    rem_d = alu_result;
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (last_s) begin
                    state_d     = ST_DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                end else begin
                    state_d     = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= {DATA_W{1'b0}};
            quo_q       <= {DATA_W{1'b0}};
            dvs_q       <= {DATA_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            quotient_q  <= {DATA_W{1'b0}};
            remainder_q <= {DATA_W{1'b0}};
`ifdef DIVU_ZERO_CHECK_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIVU_ZERO_CHECK_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

endmodule

// File: tb/tb_divu_seq_ctrl.sv
// Self-checking bench for divu_seq_ctrl: the bench plays the ALU and keeps a
// transaction-level reference model (plain / and %, fixed 32-edge latency).
module tb_divu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [5:0]  alu_funct;
    logic [31:0] alu_result;
    logic        alu_carry;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tacc   = 0;
    int lat    = 0;

`ifdef DIVU_ZERO_CHECK_EN
    localparam int  ZERO_LAT = 1;
    localparam logic ZERO_DBZ = 1'b1;
`else
    localparam int  ZERO_LAT = 33;
    localparam logic ZERO_DBZ = 1'b0;
`endif

    divu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The shared add/sub ALU as seen by the controller.
    always_comb begin
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        if (alu_funct == 6'b001010) begin
            {alu_carry, alu_result} = {1'b0, alu_src1} - {1'b0, alu_src2};
        end else if (alu_funct == 6'b001001) begin
            {alu_carry, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
        end
    end

    function automatic logic [31:0] exp_q(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    function automatic logic [31:0] exp_r(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ? a : a % b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a job is idle, busy for 32 edges, or holding a result.
    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_dbz  = 1'b0;
    int          m_left = 0;
    logic [31:0] m_q = 32'd0, m_r = 32'd0, p_q = 32'd0, p_r = 32'd0, p_d = 32'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
            end
        end else if (in_valid) begin
            p_q <= exp_q(dividend, divisor);
            p_r <= exp_r(dividend, divisor);
            p_d <= divisor;
            m_dbz <= ZERO_DBZ && (divisor == 32'd0);
            if (ZERO_LAT == 1 && divisor == 32'd0) begin
                m_done <= 1'b1;
                m_q    <= exp_q(dividend, divisor);
                m_r    <= exp_r(dividend, divisor);
            end else begin
                m_busy <= 1'b1;
                m_left <= 32;
            end
        end
    end

    // Compare process: checks every observable output against the model each cycle.
    always @(negedge clk) begin
        if (m_live && rst_n) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(m_busy || m_done)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
            if (m_done) begin
                chk("quotient", quotient, m_q);
                chk("remainder", remainder, m_r);
            end
            if (m_busy) begin
                chk("alu_funct_calc", {26'd0, alu_funct}, 32'h0000_000A);
                chk("alu_src2_calc", alu_src2, p_d);
            end else begin
                chk("alu_funct_idle", {26'd0, alu_funct}, 32'd0);
                chk("alu_src1_idle", alu_src1, 32'd0);
                chk("alu_src2_idle", alu_src2, 32'd0);
            end
        end
    end

    // Present a request and return just after the edge that accepts it.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        tacc = cyc;
        @(posedge clk);
    endtask

    // Wait for out_valid as seen at a negedge; lat = edges from accept to first visible edge.
    task automatic wait_valid(input bit drop);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (drop) in_valid = 1'b0;
            if (out_valid) break;
        end
        if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
        lat = cyc - tacc;
    endtask

    task automatic rand_job(input logic [31:0] a, input logic [31:0] b);
        bit fin;
        fin = 1'b0;
        send(a, b);
        for (int i = 0; i < 300 && !fin; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                @(posedge clk);
                fin = 1'b1;
            end
        end
        if (!fin) chk("retire_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        send(32'd100, 32'd7);
        wait_valid(1'b1);
        chk("lat_100_7", lat, 32'd33);
        chk("q_100_7", quotient, 32'd14);
        chk("r_100_7", remainder, 32'd2);

        send(32'hFFFF_FFFF, 32'd1);
        wait_valid(1'b1);
        chk("q_max_1", quotient, 32'hFFFF_FFFF);
        chk("r_max_1", remainder, 32'd0);
        send(32'd5, 32'd10);
        wait_valid(1'b1);
        chk("q_5_10", quotient, 32'd0);
        chk("r_5_10", remainder, 32'd5);

        send(32'd1234, 32'd0);
        wait_valid(1'b1);
        chk("lat_div0", lat, ZERO_LAT);
        chk("q_div0", quotient, 32'hFFFF_FFFF);
        chk("r_div0", remainder, 32'd1234);
        chk("dbz_div0", {31'd0, div_by_zero}, {31'd0, ZERO_DBZ});

        // Backpressure with a competing request that must wait.
        @(negedge clk); out_ready = 1'b0;
        send(32'd20, 32'd3);
        wait_valid(1'b1);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = 32'd40; divisor = 32'd6;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_q", quotient, 32'd6);
            chk("bp_r", remainder, 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tacc = cyc;
        @(posedge clk);
        wait_valid(1'b1);
        chk("lat_40_6", lat, 32'd33);
        chk("q_40_6", quotient, 32'd6);
        chk("r_40_6", remainder, 32'd4);

        // Reset during the tenth iteration.
        send(32'd77, 32'd2);
        @(negedge clk); in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        send(32'd1000, 32'd3);
        wait_valid(1'b1);
        chk("q_1000_3", quotient, 32'd333);
        chk("r_1000_3", remainder, 32'd1);

        // Back-to-back with in_valid held high throughout.
        send(32'd50, 32'd5);
        @(negedge clk); dividend = 32'd9; divisor = 32'd4;
        wait_valid(1'b0);
        chk("q_50_5", quotient, 32'd10);
        chk("r_50_5", remainder, 32'd0);
        send(32'd9, 32'd4);
        wait_valid(1'b1);
        chk("q_9_4", quotient, 32'd2);
        chk("r_9_4", remainder, 32'd1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = a >> $urandom_range(0, 31);
                2:       b = a + 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            rand_job(a, b);
        end

        @(negedge clk); out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/divu_seq_ctrl.md
Name: divu_seq_ctrl

Overview:
- Sequencing controller for a 32-bit unsigned restoring divider built around the shared add/sub ALU.
- Each cycle it drives ALU operands and funct, and reads back ALU result and carry.
- Produces quotient and remainder after 32 iterations.
- Sits between the requester (valid/ready handshake) and one ALU instance; the integration wrapper instantiates both.

Parameters:
- DATA_W, 32, operand width. Fixed to match the ALU datapath; any other value is unsupported.
- CNT_W, 5, iteration counter width (log2 of DATA_W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- dividend  in  32  unsigned dividend, sampled on accept
- divisor  in  32  unsigned divisor, sampled on accept
- out_valid  out  1  quotient/remainder valid
- out_ready  in  1  consumer accepts result
- quotient  out  32  result quotient
- remainder  out  32  result remainder
- div_by_zero  out  1  divisor was zero (see Optional Feature)
- alu_src1  out  32  ALU operand 1
- alu_src2  out  32  ALU operand 2
- alu_funct  out  6  ALU function select
- alu_result  in  32  ALU result
- alu_carry  in  1  ALU carry/borrow

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; quotient, remainder and counter = 0; out_valid = 0; div_by_zero = 0; in_ready = 1 (combinational from IDLE).
- Reset mid-operation aborts without producing a result.
- States:
  - IDLE: in_ready = 1. On in_valid and in_ready: load rem = 0, quo = dividend, dvs = divisor, cnt = 0; go to CALC.
  - CALC: in_ready = 0.
    - alu_src1 = {rem[30:0], quo[31]}, alu_src2 = dvs, alu_funct = 6'b001010 (subtract).
    - alu_carry = 1 means borrow (shifted rem < dvs). Then rem = alu_src1 and quo = {quo[30:0], 0}.
    - Otherwise rem = alu_result and quo = {quo[30:0], 1}.
    - cnt increments each cycle. When cnt == 31 the iteration completes and the state goes to DONE.
  - DONE: out_valid = 1; quotient = quo, remainder = rem held stable. On out_ready go to IDLE.
- ALU drive outside CALC: alu_funct = 6'b000000 (ALU outputs zero); alu_src1 and alu_src2 = 0.
- Latency: acceptance at edge N; CALC occupies the 32 cycles following; out_valid is high from edge N+33.
- Throughput: one division per 34 cycles minimum.
- in_valid while not IDLE is ignored; the request is not consumed.
- DONE with out_ready and in_valid in the same cycle: result retires, return to IDLE, new request accepted no earlier than the next cycle.
- out_ready low holds DONE indefinitely; outputs do not change.
- quotient/remainder outputs change only on entry to DONE; they are undefined-but-stable (last values) otherwise.
- Edge results:
  - dividend < divisor yields quotient 0, remainder = dividend.
  - divisor 1 yields quotient = dividend, remainder 0.

Optional Feature:
- Macro DIVU_ZERO_CHECK_EN.
- Defined: on accept with divisor == 0, skip CALC and go directly to DONE with quotient = 32'hFFFFFFFF, remainder = dividend, div_by_zero = 1. Latency is 1 cycle (out_valid from edge N+1). div_by_zero is cleared on the next accept.
- Not defined: divisor 0 runs the normal 32 iterations, naturally yielding quotient 32'hFFFFFFFF and remainder = dividend. div_by_zero is tied 0.

Decomposition:
- Shared package divu_pkg:
  - ALU_FUNCT_ADD = 6'b001001
  - ALU_FUNCT_SUB = 6'b001010
  - ALU_FUNCT_NOP = 6'b000000
  - DATA_W
  - state encoding IDLE/CALC/DONE (2-bit enum)
- No sub-module inside the controller; the ALU remains a separate instance, connected in the integration wrapper divu_top.

Test Plan:
- dividend 100, divisor 7 -> quotient 14, remainder 2, out_valid exactly 33 cycles after accept; alu_funct = 001010 during all 32 CALC cycles.
- dividend 32'hFFFFFFFF, divisor 1 -> quotient 32'hFFFFFFFF, remainder 0; then 5/10 -> quotient 0, remainder 5.
- divisor 0, dividend 1234: with DIVU_ZERO_CHECK_EN -> out_valid after 1 cycle, div_by_zero 1, quotient FFFFFFFF, remainder 1234; without it -> 33 cycles, same values, div_by_zero 0.
- Backpressure: out_ready low 5 cycles after out_valid -> results stable, in_ready 0, a concurrent in_valid is not accepted; release -> IDLE next cycle, new request accepted.
- rst_n low at CALC iteration 10 -> next cycle IDLE, out_valid 0, in_ready 1; a subsequent 1000/3 returns quotient 333, remainder 1.
- Back-to-back: in_valid held high with two requests (50/5, 9/4) -> results 10 r0 then 2 r1, each accepted only in IDLE, no lost or duplicated requests.
